// File: rtl/mem_arbiter.sv
// Byte-serial memory port arbiter between I-cache fetches and LSB loads/stores.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise LSB has fixed priority.
module mem_arbiter #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_req_valid,
  input  logic [31:0] ic_req_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        lsb_req_valid,
  input  logic        lsb_req_wr,
  input  logic [1:0]  lsb_req_size,
  input  logic [31:0] lsb_req_addr,
  input  logic [31:0] lsb_req_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic        owner_ic;
  logic        is_wr;
  logic [2:0]  len;
  logic [2:0]  p;      // read: byte on the bus; write: next byte to issue
  logic [2:0]  c;      // read bytes captured so far
  logic        pend;   // mem_din carries byte c this cycle
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;

  logic        ic_ok;
  logic        lsb_ok;
  logic        grant_ic;
  logic        grant_any;
  logic [31:0] wr_addr;
  logic [7:0]  wr_byte;
  logic        wr_ok;
  logic [31:0] cap_data;
  logic [2:0]  req_len;

`ifdef MEM_ARB_RR_EN
  logic rr_ic;
`endif

  always_comb begin
    ic_ok  = ic_req_valid && !clear;
    lsb_ok = lsb_req_valid;
`ifdef MEM_ARB_RR_EN
    grant_ic = ic_ok && (!lsb_ok || rr_ic);
`else
    grant_ic = ic_ok && !lsb_ok;
`endif
    grant_any = ic_ok || lsb_ok;
    case (lsb_req_size)
      2'd0:    req_len = 3'd1;
      2'd1:    req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  always_comb begin
    if (state == IDLE) begin
      wr_addr = lsb_req_addr;
      wr_byte = lsb_req_wdata[7:0];
    end else begin
      wr_addr = base + {29'd0, p};
      wr_byte = wdata[{p[1:0], 3'b000} +: 8];
    end
    // IO writes wait while the UART buffer is full
    wr_ok    = !((wr_addr[17:16] == IO_ADDR_HI) && io_buffer_full);
    cap_data = rbuf | ({24'd0, mem_din} << {c[1:0], 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_ic  <= 1'b0;
      is_wr     <= 1'b0;
      len       <= 3'd0;
      p         <= 3'd0;
      c         <= 3'd0;
      pend      <= 1'b0;
      base      <= 32'd0;
      wdata     <= 32'd0;
      rbuf      <= 32'd0;
      mem_a     <= 32'd0;
      mem_dout  <= 8'd0;
      mem_wr    <= 1'b0;
      ic_done   <= 1'b0;
      lsb_done  <= 1'b0;
      ic_data   <= 32'd0;
      lsb_rdata <= 32'd0;
`ifdef MEM_ARB_RR_EN
      rr_ic     <= 1'b1;
`endif
    end else if (!rdy) begin
      // Frozen: a read rewinds so the first uncaptured byte is re-presented on resume
      mem_wr <= 1'b0;
      if (state == BUSY && !is_wr) begin
        p     <= c;
        pend  <= 1'b0;
        mem_a <= base + {29'd0, c};
      end
    end else begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state    <= BUSY;
            owner_ic <= grant_ic;
            rbuf     <= 32'd0;
            c        <= 3'd0;
            pend     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_ic    <= !grant_ic;
`endif
            if (grant_ic) begin
              base  <= ic_req_addr;
              len   <= 3'd4;
              is_wr <= 1'b0;
              mem_a <= ic_req_addr;
              p     <= 3'd0;
            end else begin
              base  <= lsb_req_addr;
              wdata <= lsb_req_wdata;
              len   <= req_len;
              is_wr <= lsb_req_wr;
              mem_a <= lsb_req_addr;
              if (lsb_req_wr) begin
                mem_dout <= wr_byte;
                mem_wr   <= wr_ok;
                p        <= {2'd0, wr_ok};
              end else begin
                p <= 3'd0;
              end
            end
          end
        end
        BUSY: begin
          if (owner_ic && clear) begin
            state <= IDLE;
          end else if (is_wr) begin
            if (p == len) begin
              state    <= DONE;
              lsb_done <= 1'b1;
            end else begin
              mem_a    <= wr_addr;
              mem_dout <= wr_byte;
              mem_wr   <= wr_ok;
              p        <= p + {2'd0, wr_ok};
            end
          end else begin
            if (pend) begin
              rbuf <= cap_data;
              c    <= c + 3'd1;
              if (c == len - 3'd1) begin
                state <= DONE;
                if (owner_ic) begin
                  ic_done <= 1'b1;
                  ic_data <= cap_data;
                end else begin
                  lsb_done  <= 1'b1;
                  lsb_rdata <= cap_data;
                end
              end
            end
            pend <= (p < len);
            if (p < len) begin
              p     <= p + 3'd1;
              mem_a <= base + {29'd0, p} + 32'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing cases plus randomized traffic against a
// transaction-level memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        lsb_req_valid;
  logic        lsb_req_wr;
  logic [1:0]  lsb_req_size;
  logic [31:0] lsb_req_addr;
  logic [31:0] lsb_req_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        clear;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

`ifdef MEM_ARB_RR_EN
  localparam logic EXP_FIRST_IC = 1'b1;
`else
  localparam logic EXP_FIRST_IC = 1'b0;
`endif

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_done        (ic_done),
    .ic_data        (ic_data),
    .lsb_req_valid  (lsb_req_valid),
    .lsb_req_wr     (lsb_req_wr),
    .lsb_req_size   (lsb_req_size),
    .lsb_req_addr   (lsb_req_addr),
    .lsb_req_wdata  (lsb_req_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ram: what the bus actually did; shadow: what completed transactions imply
  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          g;
  int          ic_done_cyc;
  int          lsb_done_cyc;
  int          n_ic_done = 0;
  int          rdy_lo_cnt = 0;
  int          mism;
  int          first_cyc;
  int          ic_before;
  bit          rand_mode = 1'b0;
  logic [31:0] ic_last;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] shadow_word(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = shadow_rd(a + 32'(i));
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0000 + 32'($urandom_range(0, 63));
      1:       return 32'h0003_0000 + 32'($urandom_range(0, 7));
      2:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      default: return 32'h0000_1000 + 32'($urandom_range(0, 15));
    endcase
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]    = b;
    shadow[a] = b;
  endtask

  // One cycle: sample outputs at the falling edge, pick rdy, consume done handshakes.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (clear) begin
      clear        = 1'b0;
      ic_req_valid = 1'b0;
    end
    if (rdy_lo_cnt > 0) begin
      rdy = 1'b0;
      rdy_lo_cnt--;
    end else if (rand_mode) begin
      rdy = ($urandom_range(0, 7) != 0);
    end else begin
      rdy = 1'b1;
    end
    if (ic_done) n_ic_done++;
    if (ic_done && rdy) begin
      check_eq("ic_owner", 32'(ic_req_valid), 32'd1);
      check_eq("ic_data", ic_data, shadow_word(ic_req_addr, 4));
      ic_last      = ic_data;
      ic_req_valid = 1'b0;
      ic_done_cyc  = cyc;
    end
    if (lsb_done && rdy) begin
      check_eq("lsb_owner", 32'(lsb_req_valid), 32'd1);
      if (lsb_req_wr) begin
        for (int i = 0; i < nbytes(lsb_req_size); i++)
          shadow[lsb_req_addr + 32'(i)] = lsb_req_wdata[8*i +: 8];
      end else begin
        check_eq("lsb_rdata", lsb_rdata,
                 shadow_word(lsb_req_addr, nbytes(lsb_req_size)));
      end
      lsb_req_valid = 1'b0;
      lsb_done_cyc  = cyc;
    end
  endtask

  task automatic lsb_issue(input logic wr, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd);
    lsb_req_wr    = wr;
    lsb_req_size  = size;
    lsb_req_addr  = a;
    lsb_req_wdata = wd;
    lsb_req_valid = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = 32'd0;
    lsb_req_valid = 1'b0; lsb_req_wr = 1'b0; lsb_req_size = 2'd0;
    lsb_req_addr = 32'd0; lsb_req_wdata = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_ic_done", 32'(ic_done), 32'd0);
    check_eq("rst_lsb_done", 32'(lsb_done), 32'd0);
    check_eq("rst_ic_data", ic_data, 32'd0);
    check_eq("rst_lsb_rdata", lsb_rdata, 32'd0);

    // IC word fetch: addresses G+1..G+4, done at G+6
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    tick();
    g = cyc; ic_req_addr = 32'h1000; ic_req_valid = 1'b1; ic_done_cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 4) check_eq("ic_addr", mem_a, 32'h1000 + 32'(k - 1));
    end
    check_eq("ic_lat", ic_done_cyc - g, 6);
    check_eq("ic_word", ic_last, 32'h0000_0513);

    // Half store: EF then BE, done at G+3
    tick();
    g = cyc; lsb_issue(1'b1, 2'd1, 32'h200, 32'h1234_BEEF); lsb_done_cyc = -1;
    tick();
    check_eq("hs_wr0", {mem_wr, 15'd0, mem_dout, mem_a[7:0]}, {1'b1, 15'd0, 8'hEF, 8'h00});
    check_eq("hs_a0", mem_a, 32'h200);
    tick();
    check_eq("hs_wr1", {mem_wr, 15'd0, mem_dout, mem_a[7:0]}, {1'b1, 15'd0, 8'hBE, 8'h01});
    check_eq("hs_a1", mem_a, 32'h201);
    repeat (2) tick();
    check_eq("hs_lat", lsb_done_cyc - g, 3);
    check_eq("hs_ram_lo", 32'(ram_rd(32'h1FF)), 32'(init_byte(32'h1FF)));
    check_eq("hs_ram_hi", 32'(ram_rd(32'h202)), 32'(init_byte(32'h202)));

    // IO byte store held off by a full UART buffer (sampled high on three edges)
    tick();
    g = cyc; lsb_issue(1'b1, 2'd0, 32'h0003_0000, 32'hAABB_CC41); lsb_done_cyc = -1;
    io_buffer_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("io_stall_wr", 32'(mem_wr), 32'd0);
      if (k == 3) io_buffer_full = 1'b0;
    end
    tick();
    check_eq("io_wr", {mem_wr, 23'd0, mem_dout}, {1'b1, 23'd0, 8'h41});
    check_eq("io_a", mem_a, 32'h0003_0000);
    repeat (2) tick();
    check_eq("io_lat", lsb_done_cyc - g, 5);

    // Two ties between IC and an LSB word load
    for (int t = 0; t < 2; t++) begin
      tick();
      g = cyc; ic_done_cyc = -1; lsb_done_cyc = -1;
      ic_req_addr = 32'h0; ic_req_valid = 1'b1;
      lsb_issue(1'b0, 2'd2, 32'h100, 32'd0);
      for (int k = 0; k < 30 && (ic_req_valid || lsb_req_valid); k++) tick();
      check_eq("tie_first_ic", 32'(ic_done_cyc < lsb_done_cyc), 32'(EXP_FIRST_IC));
      first_cyc = (ic_done_cyc < lsb_done_cyc) ? ic_done_cyc : lsb_done_cyc;
      check_eq("tie_lat", first_cyc - g, 6);
      check_eq("tie_gap", (ic_done_cyc > lsb_done_cyc ? ic_done_cyc : lsb_done_cyc)
               - first_cyc, 7);
    end

    // Clear during IC byte 2 aborts it; pending LSB load is served next
    tick();
    g = cyc; ic_req_addr = 32'h2000; ic_req_valid = 1'b1;
    ic_before = n_ic_done; lsb_done_cyc = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) lsb_issue(1'b0, 2'd2, 32'h40, 32'd0);
      if (k == 3) check_eq("clr_byte2", mem_a, 32'h2002);
      if (k == 3) clear = 1'b1;
      if (k == 5) check_eq("clr_lsb_a0", mem_a, 32'h40);
    end
    check_eq("clr_no_icdone", n_ic_done - ic_before, 0);
    check_eq("clr_lsb_lat", lsb_done_cyc - g, 10);

    // rdy low for two cycles after byte 1: byte 1 re-presented, done delayed by 3
    tick();
    g = cyc; ic_req_addr = 32'h1000; ic_req_valid = 1'b1; ic_done_cyc = -1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 2) begin
        check_eq("rdy_byte1", mem_a, 32'h1001);
        rdy_lo_cnt = 2;
      end
      if (k == 5) check_eq("rdy_rewind", mem_a, 32'h1001);
    end
    check_eq("rdy_lat", ic_done_cyc - g, 9);
    check_eq("rdy_word", ic_last, 32'h0000_0513);

    // Randomized traffic with rdy gaps, IO stalls and flushes
    rand_mode = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      tick();
      io_buffer_full = ($urandom_range(0, 3) == 0);
      if (!ic_req_valid && $urandom_range(0, 2) == 0) begin
        ic_req_addr  = rand_addr();
        ic_req_valid = 1'b1;
      end
      if (!lsb_req_valid && $urandom_range(0, 2) == 0)
        lsb_issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), rand_addr(), $urandom);
      if (rdy && ic_req_valid && $urandom_range(0, 24) == 0) clear = 1'b1;
    end
    rand_mode = 1'b0;
    io_buffer_full = 1'b0;
    for (int k = 0; k < 300 && (ic_req_valid || lsb_req_valid); k++) tick();
    check_eq("drain_ic", 32'(ic_req_valid), 32'd0);
    check_eq("drain_lsb", 32'(lsb_req_valid), 32'd0);

    mism = 0;
    foreach (ram[a]) if (ram[a] !== shadow_rd(a)) mism++;
    foreach (shadow[a]) if (shadow[a] !== ram_rd(a)) mism++;
    check_eq("mem_image", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
